radix2_butterfly: RTL and testbench
===================================

// Module: radix2_butterfly
// PURPOSE
//  Radix-2 DIT butterfly stage built around the existing Q15 complex multiplier.
//  Accepts (A, B, W) beats, issues B*W to an external multiplier, delays A to match,
//  then outputs X0 = A + W*B and X1 = A - W*B. Per-beat scale-by-1/2 or saturation.
//  Buffered output with valid/ready; credit-based input backpressure, so no beat is ever dropped.
// PARAMETERS
//  WIDTH       16  sample width per component, signed Q15
//  MUL_LAT     1   multiplier latency in cycles (enable to valid); A/scale delay depth
//  FIFO_DEPTH  4   output buffer entries (power of 2, >= MUL_LAT+2)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      async active-low reset
//  in_valid       in   1      input beat valid
//  in_ready       out  1      block can accept beat
//  in_a_real/imag in   WIDTH  top input A
//  in_b_real/imag in   WIDTH  bottom input B
//  in_w_real/imag in   WIDTH  twiddle W
//  in_scale       in   1      1: divide both outputs by 2; 0: saturate
//  mul_en         out  1      multiplier enable
//  mul_a_real/imag out WIDTH  multiplier operand a (= B)
//  mul_b_real/imag out WIDTH  multiplier operand b (= W)
//  mul_res_real/imag in WIDTH multiplier product W*B
//  mul_valid      in   1      multiplier product valid
//  out_valid      out  1      output beat valid (FIFO non-empty)
//  out_ready      in   1      downstream accepts
//  out_x0_real/imag out WIDTH A + WB
//  out_x1_real/imag out WIDTH A - WB
//  ovf_sticky     out  1      set on any saturation, held until ovf_clear
//  ovf_clear      in   1      synchronous clear of ovf_sticky
// BEHAVIOUR
//  - Reset: in_ready=0 during reset, 1 first cycle after; mul_en=0, mul_* operands=0, out_valid=0,
//    out_x*=0, ovf_sticky=0, FIFO and in-flight count emptied. Mid-operation reset discards all beats.
//  - Accept: beat taken when in_valid & in_ready; that cycle mul_en=1, mul_a=B, mul_b=W
//    (combinational pass-through); A and in_scale enter an MUL_LAT-deep shift register.
//  - in_ready = (fifo_count + inflight) < FIFO_DEPTH, from registered counts, no pop lookahead.
//  - inflight: +1 on accept, -1 on mul_valid; both in one cycle: unchanged.
//    mul_valid with inflight==0 is ignored.
//  - On mul_valid: sum/diff at WIDTH+1 bits, sign-extended. scale=1: arithmetic >>>1 then
//    take WIDTH bits (cannot overflow). scale=0: saturate to [-2^(W-1), 2^(W-1)-1]; any clip sets
//    ovf_sticky. Result written to FIFO the same cycle; latency accept->out_valid = MUL_LAT+1.
//  - FIFO: pop on out_valid & out_ready; push and pop together keep count; outputs show head
//    entry, stable while out_valid & !out_ready. Full cannot be reached by a push (credit rule).
//  - ovf_sticky: set has priority over ovf_clear in the same cycle.
//  - Sustained throughput: 1 beat/cycle when out_ready held high.
// CONFIGURATION
//  BFLY_ROUND_EN defined: scale=1 path adds 1 before >>>1 (round half up).
//  Undefined: truncation (floor). Saturation path unaffected.
// TESTING
//  A=(0x2000,0),B=(0x4000,0),W=(0x7FFF,0),scale=0 -> X0=(0x5FFF,0), X1=(0xE001,0), ovf=0
//  Same, scale=1, no macro -> X0=0x2FFF, X1=0xF000; BFLY_ROUND_EN -> X0=0x3000, X1=0xF001
//  A=B=(0x7000,0),W=(0x7FFF,0),scale=0 -> X0=0x7FFF, X1=0x0001, ovf_sticky=1 until ovf_clear
//  out_ready=0, stream 8 beats -> exactly 4 accepted, in_ready=0 after; release -> 4 out in order
//  Continuous in_valid/out_ready for 16 beats -> 16 outputs in 16 cycles after 2-cycle latency
//  Reset asserted with 2 beats in flight -> out_valid=0, no stale beat after release

Source files
------------

// File: rtl/radix2_butterfly.sv
// Radix-2 DIT butterfly: X0 = A + W*B, X1 = A - W*B, around an external Q15 complex multiplier.
// Optional BFLY_ROUND_EN: the scale-by-1/2 path rounds half up instead of truncating.
module bfly_lane #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             scale_i,
  output logic [WIDTH-1:0] x0_o,
  output logic [WIDTH-1:0] x1_o,
  output logic             ovf_o
);
  logic [WIDTH:0] sum, dif, r0, r1;

  // Returns {clipped, value}; top two bits of the WIDTH+1 result disagreeing means out of range.
  function automatic logic [WIDTH:0] fit(input logic [WIDTH:0] s, input logic sc);
    if (sc) begin
`ifdef BFLY_ROUND_EN
      return {1'b0, s[WIDTH:1] + {{(WIDTH-1){1'b0}}, s[0]}};
`else
      return {1'b0, s[WIDTH:1]};
`endif
    end
    if (s[WIDTH:WIDTH-1] == 2'b01) return {2'b10, {(WIDTH-1){1'b1}}};
    if (s[WIDTH:WIDTH-1] == 2'b10) return {2'b11, {(WIDTH-1){1'b0}}};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  always_comb begin
    sum   = {a_i[WIDTH-1], a_i} + {p_i[WIDTH-1], p_i};
    dif   = {a_i[WIDTH-1], a_i} - {p_i[WIDTH-1], p_i};
    r0    = fit(sum, scale_i);
    r1    = fit(dif, scale_i);
    x0_o  = r0[WIDTH-1:0];
    x1_o  = r1[WIDTH-1:0];
    ovf_o = r0[WIDTH] | r1[WIDTH];
  end
endmodule

module radix2_butterfly #(
  parameter int WIDTH      = 16,
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a_real,
  input  logic [WIDTH-1:0] in_a_imag,
  input  logic [WIDTH-1:0] in_b_real,
  input  logic [WIDTH-1:0] in_b_imag,
  input  logic [WIDTH-1:0] in_w_real,
  input  logic [WIDTH-1:0] in_w_imag,
  input  logic             in_scale,
  output logic             mul_en,
  output logic [WIDTH-1:0] mul_a_real,
  output logic [WIDTH-1:0] mul_a_imag,
  output logic [WIDTH-1:0] mul_b_real,
  output logic [WIDTH-1:0] mul_b_imag,
  input  logic [WIDTH-1:0] mul_res_real,
  input  logic [WIDTH-1:0] mul_res_imag,
  input  logic             mul_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x0_real,
  output logic [WIDTH-1:0] out_x0_imag,
  output logic [WIDTH-1:0] out_x1_real,
  output logic [WIDTH-1:0] out_x1_imag,
  output logic             ovf_sticky,
  input  logic             ovf_clear
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] x0r, x0i, x1r, x1i;
  } ent_t;

  typedef struct packed {
    logic                  sc;
    logic [1:0][WIDTH-1:0] a;   // [1] real, [0] imag
  } dly_t;

  logic                  acc, push, pop, credit_ok, ovf_q;
  logic [1:0][WIDTH-1:0] p, x0, x1;
  logic [1:0]            lovf;
  dly_t                  dly_q [MUL_LAT];
  ent_t                  mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q, cnt_d, infl_q, infl_d;

  // Credit counts only registered state: a same-cycle pop does not free a slot early.
  assign credit_ok = ({1'b0, cnt_q} + {1'b0, infl_q}) < (CW+1)'(FIFO_DEPTH);
  assign in_ready  = rst_n & credit_ok;
  assign acc       = in_valid & in_ready;
  assign push      = mul_valid & (infl_q != '0);
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;

  assign mul_en     = acc;
  assign mul_a_real = acc ? in_b_real : '0;
  assign mul_a_imag = acc ? in_b_imag : '0;
  assign mul_b_real = acc ? in_w_real : '0;
  assign mul_b_imag = acc ? in_w_imag : '0;

  // A and scale ride a fixed-depth delay matching the multiplier latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {in_scale, in_a_real, in_a_imag};
      for (int i = 1; i < MUL_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign p = {mul_res_real, mul_res_imag};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    bfly_lane #(.WIDTH(WIDTH)) u_lane (
      .a_i    (dly_q[MUL_LAT-1].a[g]),
      .p_i    (p[g]),
      .scale_i(dly_q[MUL_LAT-1].sc),
      .x0_o   (x0[g]),
      .x1_o   (x1[g]),
      .ovf_o  (lovf[g])
    );
  end

  always_comb begin
    cnt_d  = cnt_q;
    infl_d = infl_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
    case ({acc, push})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{x0r: x0[1], x0i: x0[0], x1r: x1[1], x1i: x1[0]};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      if (push && (|lovf)) ovf_q <= 1'b1;
      else if (ovf_clear)  ovf_q <= 1'b0;
    end
  end

  assign out_x0_real = mem_q[rd_q].x0r;
  assign out_x0_imag = mem_q[rd_q].x0i;
  assign out_x1_real = mem_q[rd_q].x1r;
  assign out_x1_imag = mem_q[rd_q].x1i;
  assign ovf_sticky  = ovf_q;
endmodule

// File: tb/tb_radix2_butterfly.sv
// Directed bench for radix2_butterfly with a 1-cycle Q15 complex multiplier model.
module tb_radix2_butterfly;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_scale;
  logic [15:0] in_a_real, in_a_imag, in_b_real, in_b_imag, in_w_real, in_w_imag;
  logic        mul_en;
  logic [15:0] mul_a_real, mul_a_imag, mul_b_real, mul_b_imag;
  logic [15:0] mul_res_real = '0, mul_res_imag = '0;
  logic        mul_valid = 1'b0;
  logic        out_valid, out_ready;
  logic [15:0] out_x0_real, out_x0_imag, out_x1_real, out_x1_imag;
  logic        ovf_sticky, ovf_clear;

`ifdef BFLY_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  int n_chk = 0, n_fail = 0;

  radix2_butterfly dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_real(in_a_real), .in_a_imag(in_a_imag), .in_b_real(in_b_real), .in_b_imag(in_b_imag),
    .in_w_real(in_w_real), .in_w_imag(in_w_imag), .in_scale(in_scale),
    .mul_en(mul_en), .mul_a_real(mul_a_real), .mul_a_imag(mul_a_imag),
    .mul_b_real(mul_b_real), .mul_b_imag(mul_b_imag),
    .mul_res_real(mul_res_real), .mul_res_imag(mul_res_imag), .mul_valid(mul_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0_real(out_x0_real), .out_x0_imag(out_x0_imag),
    .out_x1_real(out_x1_real), .out_x1_imag(out_x1_imag),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cre(input logic signed [15:0] br, bi, wr, wi);
    logic signed [32:0] t;
    t = br * wr - bi * wi;
    return t[30:15];
  endfunction
  function automatic logic [15:0] cim(input logic signed [15:0] br, bi, wr, wi);
    logic signed [32:0] t;
    t = br * wi + bi * wr;
    return t[30:15];
  endfunction

  always @(posedge clk) begin
    mul_valid    <= mul_en;
    mul_res_real <= cre(mul_a_real, mul_a_imag, mul_b_real, mul_b_imag);
    mul_res_imag <= cim(mul_a_real, mul_a_imag, mul_b_real, mul_b_imag);
  end

  typedef struct {
    logic [15:0] ar, ai, br, bi, wr, wi;
    logic        sc;
    logic [63:0] et;  // {x0r,x0i,x1r,x1i} truncating
    logic [63:0] er;  // same with round-half-up
    logic        ov;
  } vec_t;
  vec_t tv [8];

  function automatic vec_t mk(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc,
                              input logic [63:0] et, er, input logic ov);
    vec_t v;
    v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.wr = wr; v.wi = wi;
    v.sc = sc; v.et = et; v.er = er; v.ov = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input vec_t v);
    in_a_real = v.ar; in_a_imag = v.ai; in_b_real = v.br; in_b_imag = v.bi;
    in_w_real = v.wr; in_w_imag = v.wi; in_scale = v.sc;
  endtask

  function automatic logic [63:0] outs();
    return {out_x0_real, out_x0_imag, out_x1_real, out_x1_imag};
  endfunction

  task automatic run_beat(input vec_t v, output logic [63:0] got, output bit ok);
    bit acc_ok;
    acc_ok = 0; ok = 0; got = '0;
    drive(v); in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin acc_ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc_ok) begin
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (out_valid) begin got = outs(); ok = 1; break; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [63:0] got;
    bit          ok;
    int          acc, k, first, last, nout, ready_bad, data_bad, stale;
    logic [63:0] q [$];
    vec_t        b;

    tv[0] = mk(16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0,
               64'h5FFF_0000_E001_0000, 64'h5FFF_0000_E001_0000, 1'b0);
    tv[1] = mk(16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1,
               64'h2FFF_0000_F000_0000, 64'h3000_0000_F001_0000, 1'b0);
    tv[2] = mk(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0,
               64'h7FFF_0000_0001_0000, 64'h7FFF_0000_0001_0000, 1'b1);
    tv[3] = mk(16'h1000, 16'hF000, 16'h2000, 16'h1000, 16'h4000, 16'h0000, 1'b0,
               64'h2000_F800_0000_E800, 64'h2000_F800_0000_E800, 1'b0);
    tv[4] = mk(16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0,
               64'h8000_0000_FFFF_0000, 64'h8000_0000_FFFF_0000, 1'b1);
    tv[5] = mk(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1,
               64'h0000_1FFF_0000_E000, 64'h0000_2000_0000_E001, 1'b0);
    tv[6] = mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1,
               64'h7FFE_C000_0000_C000, 64'h7FFF_C000_0001_C000, 1'b0);
    tv[7] = mk(16'h0000, 16'h9000, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 1'b0,
               64'h0000_8000_0000_0FFF, 64'h0000_8000_0000_0FFF, 1'b1);

    // Reset state, with in_valid high to show nothing is accepted during reset.
    drive(tv[0]); in_valid = 1'b1; out_ready = 1'b1; ovf_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {60'd0, in_ready, out_valid, mul_en, ovf_sticky}, 64'd0);
    check("rst_out", outs(), 64'd0);
    check("rst_mul", {mul_a_real, mul_a_imag, mul_b_real, mul_b_imag}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
      run_beat(tv[i], got, ok);
      check($sformatf("v%0d_done", i), {63'd0, ok}, 64'd1);
      check($sformatf("v%0d_x0", i), {32'd0, got[63:32]}, {32'd0, (ROUND ? tv[i].er[63:32] : tv[i].et[63:32])});
      check($sformatf("v%0d_x1", i), {32'd0, got[31:0]}, {32'd0, (ROUND ? tv[i].er[31:0] : tv[i].et[31:0])});
      check($sformatf("v%0d_ovf", i), {63'd0, ovf_sticky}, {63'd0, tv[i].ov});
    end

    // Sticky holds across a clean beat, then clears.
    run_beat(tv[2], got, ok);
    run_beat(tv[0], got, ok);
    check("ovf_hold", {63'd0, ovf_sticky}, 64'd1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    @(negedge clk);
    check("ovf_clear", {63'd0, ovf_sticky}, 64'd0);
    @(posedge clk); #1;

    // Set beats clear in the write cycle; also pins accept->out_valid latency at 2.
    drive(tv[2]); in_valid = 1'b1; ovf_clear = 1'b1;
    @(negedge clk);
    check("prio_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1; ovf_clear = 1'b0;
    @(negedge clk);
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    check("ovf_set_prio", {63'd0, ovf_sticky}, 64'd1);
    @(posedge clk); #1;

    // Backpressure: 8 cycles of offered beats, only 4 credits.
    out_ready = 1'b0; acc = 0;
    b = tv[0]; b.br = '0; b.bi = '0; b.wr = '0; b.wi = '0; b.sc = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      b.ar = 16'((acc + 1) << 8); b.ai = 16'(acc + 1);
      drive(b);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd4);
    @(negedge clk);
    check("bp_ready_low", {62'd0, in_ready, out_valid}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1; k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin q.push_back(outs()); k++; end
      @(posedge clk); #1;
    end
    check("bp_drained", 64'(k), 64'd4);
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      b.ar = 16'((i + 1) << 8); b.ai = 16'(i + 1);
      check($sformatf("bp_order%0d", i), q[i], {b.ar, b.ai, b.ar, b.ai});
    end

    // Sustained throughput with out_ready high.
    first = -1; last = -1; nout = 0; ready_bad = 0; data_bad = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        b.ar = 16'(16'h0100 * c + 16'h0055); b.ai = 16'(c);
        drive(b); in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (c < 16 && !in_ready) ready_bad++;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        if (outs() !== {16'(16'h0100 * nout + 16'h0055), 16'(nout),
                        16'(16'h0100 * nout + 16'h0055), 16'(nout)}) data_bad++;
        nout++;
      end
      @(posedge clk); #1;
    end
    check("tp_count", 64'(nout), 64'd16);
    check("tp_first", 64'(first), 64'd2);
    check("tp_last", 64'(last), 64'd17);
    check("tp_ready_drops", 64'(ready_bad), 64'd0);
    check("tp_data_errs", 64'(data_bad), 64'd0);

    // Reset with one beat buffered and one in the multiplier.
    out_ready = 1'b0;
    b = tv[0]; drive(b); in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("mid_rst_flags", {62'd0, out_valid, in_ready}, 64'd0);
    check("mid_rst_out", outs(), 64'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1; stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    check("no_stale", 64'(stale), 64'd0);
    run_beat(tv[0], got, ok);
    check("post_rst_beat", got, tv[0].et);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
